// File: rtl/tdc_encoder_pipe.sv
// rtl/tdc_encoder_pipe.sv - pipelined bubble-tolerant TDC fine/coarse encoder
//
// Three register stages, fully streaming, no backpressure:
//   S1 captures the delay-line snapshot and both counter samples,
//   S2 registers the fine bin, coarse select and bubble flag,
//   S3 registers the combined timestamp and the flags.
//
// Ports:
//   clk, rst        system clock, asynchronous active-high reset
//   hit_valid       qualifies fine_raw_code / counterA / counterB for one cycle
//   fine_raw_code   delay-line thermometer snapshot (FINE_BITS taps)
//   counterA/B      ripple counter samples (CNT_BITS)
//   err_clr         synchronous clear of bubble_cnt, wins over increment
//   out_valid       tdc_code, fine_code and flags valid this cycle
//   tdc_code        coarse*(2*FINE_BITS)+fine, saturated to OUT_BITS
//   fine_code       fine bin 0..2*FINE_BITS-1
//   bubble_err      snapshot had more than one transition
//   sat_err         tdc_code saturated
//   bubble_cnt      saturating count of bubble hits
module tdc_encoder_pipe #(
    parameter int FINE_BITS    = 55,
    parameter int CNT_BITS     = 5,
    parameter int OUT_BITS     = 12,
    parameter int ERR_CNT_BITS = 8,
    localparam int FINE_W      = $clog2(2 * FINE_BITS)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    hit_valid,
    input  logic [FINE_BITS-1:0]    fine_raw_code,
    input  logic [CNT_BITS-1:0]     counterA,
    input  logic [CNT_BITS-1:0]     counterB,
    input  logic                    err_clr,
    output logic                    out_valid,
    output logic [OUT_BITS-1:0]     tdc_code,
    output logic [FINE_W-1:0]       fine_code,
    output logic                    bubble_err,
    output logic                    sat_err,
    output logic [ERR_CNT_BITS-1:0] bubble_cnt
);

    localparam int BINS   = 2 * FINE_BITS;
    localparam int PCNT_W = $clog2(FINE_BITS + 1);
    localparam int SUM_W  = CNT_BITS + FINE_W + 1;
    // Compare width must hold both the sum and the all-ones code limit.
    localparam int CMP_W  = (SUM_W > OUT_BITS + 1) ? SUM_W : OUT_BITS + 1;

    // ---------------- S1: capture ----------------
    logic                 s1_valid;
    logic [FINE_BITS-1:0] s1_raw;
    logic [CNT_BITS-1:0]  s1_cnt_a;
    logic [CNT_BITS-1:0]  s1_cnt_b;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_raw   <= '0;
            s1_cnt_a <= '0;
            s1_cnt_b <= '0;
        end else begin
            // Data loads every cycle; only the valid bit qualifies it.
            s1_valid <= hit_valid;
            s1_raw   <= fine_raw_code;
            s1_cnt_a <= counterA;
            s1_cnt_b <= counterB;
        end
    end

    // ---------------- S2: fine decode ----------------
    logic [PCNT_W-1:0]   pop;
    logic [PCNT_W-1:0]   trans;
    logic                sel;
    logic [FINE_W-1:0]   fine_d;
    logic [CNT_BITS-1:0] coarse_d;

    always_comb begin
        pop   = '0;
        trans = '0;
        for (int i = 0; i < FINE_BITS; i++) begin
            pop = pop + PCNT_W'(s1_raw[i]);
        end
        for (int i = 0; i < FINE_BITS - 1; i++) begin
            trans = trans + PCNT_W'(s1_raw[i] ^ s1_raw[i+1]);
        end
    end

    // raw[0] tells which half-cycle the edge is in: a run of ones from
    // tap 0 counts up through counter A's phase, a run of zeros counts the
    // second half against counter B. Popcount makes the decode tolerant of
    // isolated bubbles instead of latching onto the first transition.
    assign sel      = s1_raw[0];
    assign fine_d   = sel ? (FINE_W'(pop) - FINE_W'(1))
                          : (FINE_W'(BINS - 1) - FINE_W'(pop));
    assign coarse_d = sel ? s1_cnt_a : s1_cnt_b;

    logic                s2_valid;
    logic [FINE_W-1:0]   s2_fine;
    logic [CNT_BITS-1:0] s2_coarse;
    logic                s2_bubble;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid  <= 1'b0;
            s2_fine   <= '0;
            s2_coarse <= '0;
            s2_bubble <= 1'b0;
        end else begin
            s2_valid  <= s1_valid;
            s2_fine   <= fine_d;
            s2_coarse <= coarse_d;
            s2_bubble <= (trans > PCNT_W'(1));
        end
    end

    // ---------------- S3: combine and saturate ----------------
    logic [CMP_W-1:0] sum;
    logic             sat_d;

    assign sum   = CMP_W'(s2_coarse) * CMP_W'(BINS) + CMP_W'(s2_fine);
    assign sat_d = (sum > CMP_W'({OUT_BITS{1'b1}}));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid  <= 1'b0;
            tdc_code   <= '0;
            fine_code  <= '0;
            bubble_err <= 1'b0;
            sat_err    <= 1'b0;
        end else begin
            out_valid <= s2_valid;
            // Result fields hold their last value between hits.
            if (s2_valid) begin
                tdc_code   <= sat_d ? {OUT_BITS{1'b1}} : sum[OUT_BITS-1:0];
                fine_code  <= s2_fine;
                bubble_err <= s2_bubble;
                sat_err    <= sat_d;
            end
        end
    end

    // Counts in step with the output register so bubble_cnt already
    // includes a bubble hit in the cycle its out_valid is shown.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bubble_cnt <= '0;
        end else if (err_clr) begin
            bubble_cnt <= '0;
        end else if (s2_valid && s2_bubble && (bubble_cnt != {ERR_CNT_BITS{1'b1}})) begin
            bubble_cnt <= bubble_cnt + ERR_CNT_BITS'(1);
        end
    end

endmodule

// File: tb/tb_tdc_encoder_pipe.sv
// tb/tb_tdc_encoder_pipe.sv - self-checking bench for tdc_encoder_pipe
module tb_tdc_encoder_pipe;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        hit_valid = 1'b0;
    logic        err_clr = 1'b0;
    logic [54:0] raw = '0;
    logic [4:0]  ca = '0;
    logic [4:0]  cb = '0;

    logic        ov,  bub,  sat;
    logic [11:0] code;
    logic [6:0]  fine;
    logic [7:0]  bcnt;
    logic        ov2, bub2, sat2;
    logic [10:0] code2;
    logic [6:0]  fine2;
    logic [7:0]  bcnt2;

    tdc_encoder_pipe dut (
        .clk(clk), .rst(rst), .hit_valid(hit_valid), .fine_raw_code(raw),
        .counterA(ca), .counterB(cb), .err_clr(err_clr),
        .out_valid(ov), .tdc_code(code), .fine_code(fine),
        .bubble_err(bub), .sat_err(sat), .bubble_cnt(bcnt)
    );

    tdc_encoder_pipe #(.OUT_BITS(11)) dut11 (
        .clk(clk), .rst(rst), .hit_valid(hit_valid), .fine_raw_code(raw),
        .counterA(ca), .counterB(cb), .err_clr(err_clr),
        .out_valid(ov2), .tdc_code(code2), .fine_code(fine2),
        .bubble_err(bub2), .sat_err(sat2), .bubble_cnt(bcnt2)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [54:0] raw;
        logic [4:0]  a;
        logic [4:0]  b;
        int          fine;
        int          code;
        int          bub;
        int          sat;
    } vec_t;

    typedef struct {
        int code;
        int fine;
        int bub;
    } exp_t;

    exp_t exp_q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // Reference: decode from the thermometer rules with plain arithmetic.
    function automatic exp_t model(input logic [54:0] r, input int a, input int b, input int out_bits);
        exp_t e;
        int p, tr, coarse, sum, lim;
        p  = $countones(r);
        tr = 0;
        for (int i = 0; i < 54; i++) if (r[i] != r[i+1]) tr++;
        e.fine = r[0] ? p - 1 : 110 - p - 1;
        coarse = r[0] ? a : b;
        sum    = coarse * 110 + e.fine;
        lim    = (1 << out_bits) - 1;
        e.code = (sum > lim) ? lim : sum;
        e.bub  = (tr > 1) ? 1 : 0;
        return e;
    endfunction

    task automatic drive(input logic [54:0] r, input logic [4:0] a, input logic [4:0] b);
        @(negedge clk);
        raw = r; ca = a; cb = b; hit_valid = 1'b1;
    endtask

    // Idle cycle with junk data to show invalid data never reaches outputs.
    task automatic idle();
        @(negedge clk);
        hit_valid = 1'b0;
        raw = 55'({$urandom(), $urandom()});
        ca  = 5'($urandom());
        cb  = 5'($urandom());
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_ov"},   64'(ov),   0);
        chk({tag, "_code"}, 64'(code), 0);
        chk({tag, "_fine"}, 64'(fine), 0);
        chk({tag, "_bub"},  64'(bub),  0);
        chk({tag, "_sat"},  64'(sat),  0);
        chk({tag, "_bcnt"}, 64'(bcnt), 0);
    endtask

    function automatic logic [54:0] clean_raw();
        logic [54:0] t;
        int k;
        k = $urandom_range(1, 55);
        t = 55'(1) << k;
        t = t - 55'(1);
        return ($urandom_range(0, 1) == 1) ? t : ~t;
    endfunction

    vec_t tbl[5];

    initial begin
        tbl[0] = '{{55{1'b1}},         5'd3, 5'd9,  54,  384,  0, 0};
        tbl[1] = '{55'h1,              5'd0, 5'd0,  0,   0,    0, 0};
        tbl[2] = '{55'h0,              5'd0, 5'd31, 109, 3519, 0, 0};
        tbl[3] = '{{{54{1'b1}}, 1'b0}, 5'd0, 5'd2,  55,  275,  0, 0};
        tbl[4] = '{55'hB,              5'd1, 5'd0,  2,   112,  1, 0};

        // Reset state
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_reset_state("reset");

        // Directed vectors with exact latency
        for (int i = 0; i < 5; i++) begin
            drive(tbl[i].raw, tbl[i].a, tbl[i].b);
            idle();
            @(negedge clk);
            chk($sformatf("vec%0d_early", i), 64'(ov), 0);
            @(negedge clk);
            chk($sformatf("vec%0d_valid", i), 64'(ov),   1);
            chk($sformatf("vec%0d_fine", i),  64'(fine), 64'(tbl[i].fine));
            chk($sformatf("vec%0d_code", i),  64'(code), 64'(tbl[i].code));
            chk($sformatf("vec%0d_bub", i),   64'(bub),  64'(tbl[i].bub));
            chk($sformatf("vec%0d_sat", i),   64'(sat),  64'(tbl[i].sat));
            @(negedge clk);
            chk($sformatf("vec%0d_drop", i), 64'(ov),   0);
            chk($sformatf("vec%0d_hold", i), 64'(code), 64'(tbl[i].code));
        end
        chk("bubble_cnt_first", 64'(bcnt), 1);

        // Streaming: clean bursts, then arbitrary snapshots
        for (int burst = 0; burst < 2; burst++) begin
            for (int i = 0; i < 23; i++) begin
                @(negedge clk);
                if (i >= 3) begin
                    chk($sformatf("stream%0d_valid_%0d", burst, i), 64'(ov), 1);
                    if (ov && exp_q.size() > 0) begin
                        exp_t e;
                        e = exp_q.pop_front();
                        chk($sformatf("stream%0d_code_%0d", burst, i), 64'(code), 64'(e.code));
                        chk($sformatf("stream%0d_fine_%0d", burst, i), 64'(fine), 64'(e.fine));
                        chk($sformatf("stream%0d_bub_%0d", burst, i),  64'(bub),  64'(e.bub));
                    end
                end else begin
                    chk($sformatf("stream%0d_idle_%0d", burst, i), 64'(ov), 0);
                end
                if (i < 20) begin
                    raw = (burst == 0) ? clean_raw() : 55'({$urandom(), $urandom()});
                    ca  = 5'($urandom());
                    cb  = 5'($urandom());
                    hit_valid = 1'b1;
                    exp_q.push_back(model(raw, int'(ca), int'(cb), 12));
                end else begin
                    hit_valid = 1'b0;
                end
            end
        end
        chk("stream_drained", 64'(exp_q.size()), 0);

        // err_clr alone
        @(negedge clk);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        chk("err_clr_alone", 64'(bcnt), 0);

        // Saturating counter
        for (int i = 0; i < 300; i++) drive(55'hB, 5'd1, 5'd0);
        idle();
        repeat (3) @(negedge clk);
        chk("bubble_cnt_sat", 64'(bcnt), 255);

        // err_clr coincident with a counted bubble hit
        drive(55'hB, 5'd1, 5'd0);
        idle();
        @(negedge clk);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        chk("clr_coinc_valid", 64'(ov),   1);
        chk("clr_coinc_bub",   64'(bub),  1);
        chk("clr_coinc_cnt",   64'(bcnt), 0);
        @(negedge clk);
        chk("clr_coinc_after", 64'(bcnt), 0);

        // OUT_BITS=11 saturation boundary
        drive(55'h0, 5'd0, 5'd31);
        idle();
        repeat (2) @(negedge clk);
        chk("ob11_sat_code", 64'(code2), 2047);
        chk("ob11_sat_flag", 64'(sat2),  1);
        chk("ob12_nosat",    64'(code),  3519);
        drive(55'h0, 5'd0, 5'd17);
        idle();
        repeat (2) @(negedge clk);
        chk("ob11_code", 64'(code2), 1979);
        chk("ob11_flag", 64'(sat2),  0);

        // Reset with two hits in flight
        begin
            int seen;
            drive(55'h7, 5'd4, 5'd4);
            drive(55'h3F, 5'd5, 5'd5);
            @(negedge clk);
            hit_valid = 1'b0;
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
            check_reset_state("midrst");
            seen = 0;
            repeat (6) begin
                @(negedge clk);
                if (ov) seen++;
            end
            chk("midrst_no_out", 64'(seen), 0);
            drive(55'h7, 5'd4, 5'd0);
            idle();
            @(negedge clk);
            chk("midrst_new_early", 64'(ov), 0);
            @(negedge clk);
            chk("midrst_new_valid", 64'(ov),   1);
            chk("midrst_new_code",  64'(code), 442);
            chk("midrst_new_fine",  64'(fine), 2);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
